// File: rtl/wb_regfile.sv
// Writeback-side 32 x 32 register file. Two registered read ports with
// same-cycle write-to-read bypass, plus a wrapping count of committed writes.
module wb_regfile #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
) (
  input  logic              clock_i,
  input  logic              reset_ni,
  input  logic              wb_en_i,
  input  logic [ADDR_W-1:0] wb_rd_i,
  input  logic [DATA_W-1:0] wb_dato_i,
  input  logic              rd_en_i,
  input  logic [ADDR_W-1:0] rs_addr_i,
  input  logic [ADDR_W-1:0] rt_addr_i,
  output logic [DATA_W-1:0] rs_dato_o,
  output logic [DATA_W-1:0] rt_dato_o,
  output logic [15:0]       wr_count_o
);

  localparam int NREG = 1 << ADDR_W;

  logic [DATA_W-1:0] rf_val [NREG];
  logic              wr_commit;
  logic [DATA_W-1:0] rs_val, rt_val;
  logic [DATA_W-1:0] rs_dato_q, rs_dato_d;
  logic [DATA_W-1:0] rt_dato_q, rt_dato_d;
  logic [15:0]       wr_count_q, wr_count_d;

  // r0 has no storage; writes to it are dropped and never counted.
  assign rf_val[0]  = '0;
  assign wr_commit  = wb_en_i && (wb_rd_i != '0);

  generate
    for (genvar gi = 1; gi < NREG; gi++) begin : g_reg
      logic [DATA_W-1:0] reg_q;
      always_ff @(posedge clock_i or negedge reset_ni) begin
        if (!reset_ni) begin
          reg_q <= '0;
        end else if (wb_en_i && (wb_rd_i == ADDR_W'(gi))) begin
          reg_q <= wb_dato_i;
        end
      end
      assign rf_val[gi] = reg_q;
    end
  endgenerate

  // Bypass only applies to a real commit, so a discarded r0 write never leaks.
  always_comb begin
    rs_val = rf_val[rs_addr_i];
    rt_val = rf_val[rt_addr_i];
    if (wr_commit && (wb_rd_i == rs_addr_i)) rs_val = wb_dato_i;
    if (wr_commit && (wb_rd_i == rt_addr_i)) rt_val = wb_dato_i;
  end

  always_comb begin
    rs_dato_d  = rs_dato_q;
    rt_dato_d  = rt_dato_q;
    wr_count_d = wr_count_q;
    if (rd_en_i) begin
      rs_dato_d = rs_val;
      rt_dato_d = rt_val;
    end
    if (wr_commit) wr_count_d = wr_count_q + 16'd1;
  end

  always_ff @(posedge clock_i or negedge reset_ni) begin
    if (!reset_ni) begin
      rs_dato_q  <= '0;
      rt_dato_q  <= '0;
      wr_count_q <= '0;
    end else begin
      rs_dato_q  <= rs_dato_d;
      rt_dato_q  <= rt_dato_d;
      wr_count_q <= wr_count_d;
    end
  end

  assign rs_dato_o  = rs_dato_q;
  assign rt_dato_o  = rt_dato_q;
  assign wr_count_o = wr_count_q;

endmodule

// File: tb/tb_wb_regfile.sv
// Directed bench for wb_regfile: reset, write/read, bypass, r0, hold, wrap.
module tb_wb_regfile;

  logic        clock_i = 1'b0;
  logic        reset_ni;
  logic        wb_en_i;
  logic [4:0]  wb_rd_i;
  logic [31:0] wb_dato_i;
  logic        rd_en_i;
  logic [4:0]  rs_addr_i;
  logic [4:0]  rt_addr_i;
  logic [31:0] rs_dato_o;
  logic [31:0] rt_dato_o;
  logic [15:0] wr_count_o;

  int errors = 0;
  int checks = 0;

  always #5 clock_i = ~clock_i;

  wb_regfile #(.DATA_W(32), .ADDR_W(5)) dut (
    .clock_i   (clock_i),
    .reset_ni  (reset_ni),
    .wb_en_i   (wb_en_i),
    .wb_rd_i   (wb_rd_i),
    .wb_dato_i (wb_dato_i),
    .rd_en_i   (rd_en_i),
    .rs_addr_i (rs_addr_i),
    .rt_addr_i (rt_addr_i),
    .rs_dato_o (rs_dato_o),
    .rt_dato_o (rt_dato_o),
    .wr_count_o(wr_count_o)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, obs, exp);
    end else begin
      $display("ok   %s: 0x%08h", tag, obs);
    end
  endtask

  task automatic step();
    @(posedge clock_i);
    #1;
  endtask

  task automatic drive(input logic we, input logic [4:0] rd, input logic [31:0] d,
                       input logic re, input logic [4:0] rs, input logic [4:0] rt);
    wb_en_i = we; wb_rd_i = rd; wb_dato_i = d;
    rd_en_i = re; rs_addr_i = rs; rt_addr_i = rt;
  endtask

  initial begin
    reset_ni = 1'b0;
    drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 5'd0);
    #12;
    check("reset_rs", rs_dato_o, 32'h0);
    check("reset_rt", rt_dato_o, 32'h0);
    check("reset_cnt", {16'h0, wr_count_o}, 32'h0);
    step();
    reset_ni = 1'b1;

    // Basic write then read on the following edge
    drive(1'b1, 5'd3, 32'h12345678, 1'b0, 5'd0, 5'd0);
    step();
    drive(1'b0, 5'd0, 32'h0, 1'b1, 5'd3, 5'd0);
    step();
    check("basic_rs", rs_dato_o, 32'h12345678);
    check("basic_rt", rt_dato_o, 32'h0);
    check("basic_cnt", {16'h0, wr_count_o}, 32'd1);

    // Bypass: same-edge write/read returns new data on both ports
    drive(1'b1, 5'd7, 32'h00000001, 1'b0, 5'd0, 5'd0);
    step();
    drive(1'b1, 5'd7, 32'hCAFEF00D, 1'b1, 5'd7, 5'd7);
    step();
    check("bypass_rs", rs_dato_o, 32'hCAFEF00D);
    check("bypass_rt", rt_dato_o, 32'hCAFEF00D);
    check("bypass_cnt", {16'h0, wr_count_o}, 32'd3);
    drive(1'b0, 5'd0, 32'h0, 1'b1, 5'd7, 5'd3);
    step();
    check("stored_r7", rs_dato_o, 32'hCAFEF00D);
    check("stored_r3", rt_dato_o, 32'h12345678);

    // r0 protection, including no bypass from a discarded write
    drive(1'b1, 5'd0, 32'hFFFFFFFF, 1'b1, 5'd0, 5'd0);
    step();
    check("r0_rs", rs_dato_o, 32'h0);
    check("r0_rt", rt_dato_o, 32'h0);
    check("r0_cnt", {16'h0, wr_count_o}, 32'd3);
    drive(1'b0, 5'd0, 32'h0, 1'b1, 5'd7, 5'd7);
    step();

    // Hold with rd_en=0 while r9 is written, then disabled write
    drive(1'b1, 5'd9, 32'h000000AA, 1'b0, 5'd9, 5'd9);
    step();
    check("hold_rs", rs_dato_o, 32'hCAFEF00D);
    check("hold_rt", rt_dato_o, 32'hCAFEF00D);
    check("hold_cnt", {16'h0, wr_count_o}, 32'd4);
    drive(1'b0, 5'd9, 32'h000000BB, 1'b0, 5'd9, 5'd9);
    step();
    drive(1'b0, 5'd0, 32'h0, 1'b1, 5'd9, 5'd3);
    step();
    check("nowe_r9", rs_dato_o, 32'h000000AA);
    check("nowe_r3", rt_dato_o, 32'h12345678);
    check("nowe_cnt", {16'h0, wr_count_o}, 32'd4);

    // Asynchronous reset between a write and the following read
    drive(1'b1, 5'd5, 32'hDEADBEEF, 1'b0, 5'd0, 5'd0);
    step();
    check("pre_rst_cnt", {16'h0, wr_count_o}, 32'd5);
    drive(1'b0, 5'd0, 32'h0, 1'b1, 5'd5, 5'd9);
    #2;
    reset_ni = 1'b0;
    #1;
    check("arst_rs", rs_dato_o, 32'h0);
    check("arst_rt", rt_dato_o, 32'h0);
    check("arst_cnt", {16'h0, wr_count_o}, 32'h0);
    step();
    check("arst_hold_rs", rs_dato_o, 32'h0);
    reset_ni = 1'b1;
    step();
    check("post_rst_r5", rs_dato_o, 32'h0);
    check("post_rst_r9", rt_dato_o, 32'h0);

    // Counter wrap: 65535 writes to r1, then one more
    for (int i = 0; i < 65535; i++) begin
      drive(1'b1, 5'd1, 32'(i), 1'b0, 5'd0, 5'd0);
      step();
    end
    check("cnt_ffff", {16'h0, wr_count_o}, 32'h0000FFFF);
    drive(1'b1, 5'd1, 32'h0000FFFF, 1'b0, 5'd0, 5'd0);
    step();
    check("cnt_wrap", {16'h0, wr_count_o}, 32'h0);
    drive(1'b1, 5'd31, 32'h80000000, 1'b0, 5'd0, 5'd0);
    step();
    check("cnt_after", {16'h0, wr_count_o}, 32'd1);
    drive(1'b0, 5'd0, 32'h0, 1'b1, 5'd31, 5'd1);
    step();
    check("r31_read", rs_dato_o, 32'h80000000);
    check("r1_read", rt_dato_o, 32'h0000FFFF);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/wb_regfile.md
# wb_regfile

Writeback-side register file for the 5-stage pipeline: consumes the write bundle leaving the MEM/WB pipeline register and commits it into a 32 x 32-bit architectural register file. It also serves the two decode-stage read ports that feed ID/EX. Reads are registered and include write-to-read bypass, so a value written back in cycle N is visible to a read issued in that same cycle N.

## Interface
- DATA_W, 32, register width
- ADDR_W, 5, register index width (2^ADDR_W registers)

- clock  in  1  rising-edge clock for all state
- reset  in  1  asynchronous, active-low; clears every register and output
- wb_en  in  1  write enable from the MEM/WB register's writeback flag
- wb_rd  in  ADDR_W  destination register index
- wb_dato  in  DATA_W  writeback data (MEM/WB payload)
- rd_en  in  1  decode read strobe; when low, read outputs hold
- rs_addr  in  ADDR_W  read port A index
- rt_addr  in  ADDR_W  read port B index
- rs_dato  out  DATA_W  registered read data A
- rt_dato  out  DATA_W  registered read data B
- wr_count  out  16  count of committed (non-r0) writes, wraps

## Operation
- Storage: registers r1..r31 are flops; r0 has no storage and always reads 0.
- Write: on a rising clock edge with wb_en=1 and wb_rd!=0, mem[wb_rd] <= wb_dato and wr_count <= wr_count+1 (mod 2^16).
- Writes with wb_rd=0 are discarded and do not increment wr_count.
- Read: on a rising clock edge with rd_en=1, rs_dato <= value(rs_addr) and rt_dato <= value(rt_addr).
- value(a) = 0 if a=0; else wb_dato if wb_en=1 and wb_rd=a (bypass); else mem[a].
- rd_en=0: rs_dato/rt_dato hold their previous values; writes still commit.
- rs_addr=rt_addr: both outputs get identical data, bypass included.
- No state machine; the block is a storage array plus registered read path and counter.

## Timing
- Reset (reset=0, any time, independent of clock): all mem[1..31]=0, rs_dato=0, rt_dato=0, wr_count=0, effective immediately; outputs stay 0 while reset is held.
- Deassertion of reset is synchronised externally; the first active edge after release behaves normally.
- Write latency: data presented with wb_en at edge N is stored at edge N.
- Read latency: 1 cycle; addresses sampled at edge N appear on rs_dato/rt_dato after edge N.
- Same-cycle write/read of the same index at edge N: read returns the new wb_dato, never the stale value.
- Read at edge N+1 of an index written at edge N: returns the stored value (no bypass needed).
- Reset asserted between a write and the following read: the read returns 0.
- wr_count wraps 0xFFFF -> 0x0000 on the next counted write.

## Test plan
- Reset: drive reset=0 mid-run after writing r5=0xDEADBEEF -> rs_dato, rt_dato and wr_count read 0 immediately; after release, a read of r5 returns 0x00000000.
- Basic write/read: write r3=0x12345678 at edge N; read rs_addr=3, rt_addr=0 at edge N+1 -> after edge N+1, rs_dato=0x12345678, rt_dato=0, wr_count=1.
- Bypass: mem[7]=0x1 already; at the same edge, write r7=0xCAFEF00D and read rs_addr=rt_addr=7 -> after that edge, both outputs are 0xCAFEF00D.
- r0 protection: write r0=0xFFFFFFFF with wb_en=1, then read r0 on both ports -> both outputs 0, wr_count unchanged.
- Hold and disabled write: rd_en=0 while r9 is written to 0xAA -> outputs unchanged. Write with wb_en=0 to r9=0xBB, then read r9 -> 0x000000AA.
- Counter wrap: preload by 65535 writes to r1, then one more write -> wr_count goes 0xFFFF then 0x0000. Then write r31=0x80000000 and read it -> 0x80000000.
